key_led_ctrl: RTL and testbench
===============================

// Module: key_led_ctrl
// PURPOSE
//  N-channel push-button front end for DE0-Nano boards. Each key input is synchronised,
//  debounced and edge-detected, then drives its LED in one of three modes:
//  momentary, toggle, or exclusive (radio-button: the last key pressed owns the lit LED).
//  Sits between the board key pins and LED pins or downstream control logic (e.g. PWM
//  channel select). Successor of the two-key set/clear LED switch.
// PARAMETERS
//  N_CH            2      number of key/LED channels, 1..8
//  DEBOUNCE_CYCLES 50000  clocks a new level must be stable before it is accepted (>=2; 1 ms at 50 MHz)
//  KEY_ACTIVE_LOW  1      1: key pin reads 0 when pressed; 0: reads 1 when pressed
//  MODE            2      0 momentary, 1 toggle, 2 exclusive
//  INIT_SEL        0      exclusive mode: index of the LED lit after reset; N_CH = none lit
// PORTS
//  clk          in   1     system clock, the only clock
//  rst          in   1     synchronous reset, active-high
//  key          in   N_CH  raw asynchronous key pins
//  led          out  N_CH  LED drive, 1 = on
//  press_pulse  out  N_CH  1-clk pulse per accepted press
//  release_pulse out N_CH  1-clk pulse per accepted release
//  pressed      out  N_CH  debounced level, 1 = held
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is synchronous and active-high.
//  Reset (rst=1 at a rising edge): sync flops, pressed, counters, pulses = 0;
//   led = 0, except MODE 2 with INIT_SEL<N_CH: led = one-hot(INIT_SEL). Reset overrides everything
//   and aborts any debounce in progress; a key held through reset is accepted as a fresh press.
//  Per channel: p = key ^ KEY_ACTIVE_LOW; 2-flop synchroniser -> s2.
//  Debounce counter, width clog2(DEBOUNCE_CYCLES):
//   s2 == pressed          -> cnt <= 0
//   s2 != pressed, cnt < DEBOUNCE_CYCLES-1 -> cnt <= cnt+1
//   s2 != pressed, cnt == DEBOUNCE_CYCLES-1 -> pressed <= s2, cnt <= 0
//   A glitch shorter than DEBOUNCE_CYCLES clocks restarts the count; never accepted.
//  press_pulse / release_pulse: registered, high for exactly the one cycle after pressed rises / falls.
//  Latency: pin change -> pressed, pulse and led all update DEBOUNCE_CYCLES+2 clocks after the
//   first edge that samples the new level. press and release events are all emitted, none dropped.
//  LED update (registered, same edge as pressed changes):
//   MODE 0: led[i] = pressed[i].
//   MODE 1: on accepted press led[i] <= ~led[i]; releases have no effect.
//   MODE 2: on accepted press of i, led <= one-hot(i). Releases have no effect.
//    Simultaneous presses in one cycle: lowest index wins. Pressing the owner again: no change.
//  Channels are independent except for the MODE 2 arbitration.
//  No X on outputs after the first reset cycle; all outputs are driven from flops.
// TESTING  (bench: N_CH=3, DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1)
//  1 rst 2 clk, then key=3'b111 stable -> led=0 (MODE 0/1), led=3'b001 (MODE 2, INIT_SEL=0),
//    all pulses and pressed=0.
//  2 MODE 0: key[1]=0 held 20 clk -> pressed[1] and led[1] rise exactly 6 clk later,
//    press_pulse[1]=1 for 1 clk; release -> led[1]=0 6 clk after release, release_pulse[1] for 1 clk.
//  3 bounce: key[0] low 3 clk, high 1 clk, low 3 clk -> no press; then low 4+ clk -> single press.
//  4 MODE 1: 3 clean presses on key[2] -> led[2] goes 1,0,1; exactly 3 press_pulse[2].
//  5 MODE 2: press key[2] -> led=3'b100; key[0] and key[1] pressed on the same clk -> led=3'b001.
//  6 MODE 1: press key[0] mid-debounce (cnt=2), assert rst 1 clk, keep key held
//    -> led=0 after reset; led[0]=1 6 clk after rst released.

Source files
------------

// File: rtl/key_led_ctrl_if.sv
// key_led_ctrl_if: key pins in, LED drive and debounced key status out
interface key_led_ctrl_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] key;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] pressed;

    modport master (
        output key,
        input  led, press_pulse, release_pulse, pressed
    );

    modport slave (
        input  key,
        output led, press_pulse, release_pulse, pressed
    );
endinterface

// File: rtl/key_led_ctrl.sv
// key_led_ctrl: per-channel key sync/debounce/edge detect driving LEDs in momentary, toggle or exclusive mode
module key_led_ctrl #(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int MODE            = 2,
    parameter int INIT_SEL        = 0
) (
    input logic           clk,
    input logic           rst,
    key_led_ctrl_if.slave io
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_CH-1:0] LED_INIT = (MODE == 2 && INIT_SEL < N_CH) ? N_CH'(1) << INIT_SEL : '0;

    logic [N_CH-1:0] p;
    logic [N_CH-1:0] s1_q, s2_q;
    logic [N_CH-1:0] pressed_q, pressed_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] rel_q, rel_d;
    logic [N_CH-1:0] led_q, led_d;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];

    assign p = KEY_ACTIVE_LOW != 0 ? ~io.key : io.key;

    // debounce: count while the synchronised level differs, accept once it has held long enough
    always_comb begin
        pressed_d = pressed_q;
        press_d   = '0;
        rel_d     = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != pressed_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    pressed_d[i] = s2_q[i];
                    press_d[i]   = s2_q[i];
                    rel_d[i]     = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // LED next state; descending scan makes the lowest simultaneous press win in exclusive mode
    always_comb begin
        led_d = MODE == 0 ? pressed_d : MODE == 1 ? led_q ^ press_d : led_q;
        if (MODE == 2) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (press_d[i]) led_d = N_CH'(1) << i;
            end
        end
    end

    // all state registered; reset also discards any debounce in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            pressed_q <= '0;
            press_q   <= '0;
            rel_q     <= '0;
            led_q     <= LED_INIT;
            cnt_q     <= '{default: '0};
        end else begin
            s1_q      <= p;
            s2_q      <= s1_q;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            led_q     <= led_d;
            cnt_q     <= cnt_d;
        end
    end

    assign io.led           = led_q;
    assign io.press_pulse   = press_q;
    assign io.release_pulse = rel_q;
    assign io.pressed       = pressed_q;
endmodule

// File: tb/tb_key_led_ctrl.sv
// tb_key_led_ctrl: directed vectors against momentary, toggle and exclusive instances sharing one key bus
module tb_key_led_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key = 3'b111;
    int         n_vec = 0;
    int         n_err = 0;
    int         np0 [3] = '{0, 0, 0};
    int         nr0 [3] = '{0, 0, 0};
    int         np1 [3] = '{0, 0, 0};
    int         base_p, base_r;

    key_led_ctrl_if #(.N_CH(3)) if_m0 ();
    key_led_ctrl_if #(.N_CH(3)) if_m1 ();
    key_led_ctrl_if #(.N_CH(3)) if_m2 ();

    assign if_m0.key = key;
    assign if_m1.key = key;
    assign if_m2.key = key;

    key_led_ctrl #(.N_CH(3), .DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(1), .MODE(0), .INIT_SEL(0))
        u_m0 (.clk(clk), .rst(rst), .io(if_m0.slave));
    key_led_ctrl #(.N_CH(3), .DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(1), .MODE(1), .INIT_SEL(0))
        u_m1 (.clk(clk), .rst(rst), .io(if_m1.slave));
    key_led_ctrl #(.N_CH(3), .DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(1), .MODE(2), .INIT_SEL(0))
        u_m2 (.clk(clk), .rst(rst), .io(if_m2.slave));

    always #5 clk = ~clk;

    // pulse tallies sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (if_m0.press_pulse[i])   np0[i]++;
            if (if_m0.release_pulse[i]) nr0[i]++;
            if (if_m1.press_pulse[i])   np1[i]++;
        end
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key = 3'b111;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset state
        do_reset();
        check("rst_led_m0", 8'(if_m0.led), 8'h0);
        check("rst_led_m1", 8'(if_m1.led), 8'h0);
        check("rst_led_m2", 8'(if_m2.led), 8'h1);
        check("rst_pressed", 8'(if_m0.pressed), 8'h0);
        check("rst_press_pulse", 8'(if_m0.press_pulse), 8'h0);
        check("rst_release_pulse", 8'(if_m0.release_pulse), 8'h0);
        tick(8);
        check("idle_led_m2", 8'(if_m2.led), 8'h1);
        check("idle_pressed", 8'(if_m1.pressed), 8'h0);

        // 2: momentary, exact latency on press and release
        key = 3'b101;
        tick(5);
        check("m0_press_early", 8'(if_m0.led), 8'h0);
        tick(1);
        check("m0_press_led", 8'(if_m0.led), 8'h2);
        check("m0_press_pressed", 8'(if_m0.pressed), 8'h2);
        check("m0_press_pulse", 8'(if_m0.press_pulse), 8'h2);
        tick(1);
        check("m0_press_pulse_end", 8'(if_m0.press_pulse), 8'h0);
        check("m0_held_led", 8'(if_m0.led), 8'h2);
        tick(13);
        key = 3'b111;
        tick(5);
        check("m0_rel_early", 8'(if_m0.led), 8'h2);
        tick(1);
        check("m0_rel_led", 8'(if_m0.led), 8'h0);
        check("m0_rel_pulse", 8'(if_m0.release_pulse), 8'h2);
        tick(1);
        check("m0_rel_pulse_end", 8'(if_m0.release_pulse), 8'h0);

        // 3: bounce rejected, then a 4-clock press accepted once
        do_reset();
        base_p = np0[0];
        base_r = nr0[0];
        key = 3'b110;
        tick(3);
        key = 3'b111;
        tick(1);
        key = 3'b110;
        tick(3);
        key = 3'b111;
        tick(8);
        check("bounce_pressed", 8'(if_m0.pressed), 8'h0);
        check("bounce_pulses", 8'(np0[0] - base_p), 8'd0);
        key = 3'b110;
        tick(4);
        key = 3'b111;
        tick(2);
        check("short_press_pressed", 8'(if_m0.pressed), 8'h1);
        tick(10);
        check("short_press_count", 8'(np0[0] - base_p), 8'd1);
        check("short_release_count", 8'(nr0[0] - base_r), 8'd1);
        check("short_release_pressed", 8'(if_m0.pressed), 8'h0);

        // 4: toggle mode, three presses on key 2
        do_reset();
        base_p = np1[2];
        for (int k = 0; k < 3; k++) begin
            key = 3'b011;
            tick(8);
            check($sformatf("m1_toggle_%0d", k), 8'(if_m1.led), (k % 2 == 0) ? 8'h4 : 8'h0);
            key = 3'b111;
            tick(8);
            check($sformatf("m1_after_rel_%0d", k), 8'(if_m1.led), (k % 2 == 0) ? 8'h4 : 8'h0);
        end
        check("m1_press_count", 8'(np1[2] - base_p), 8'd3);

        // 5: exclusive mode ownership and simultaneous press arbitration
        do_reset();
        key = 3'b011;
        tick(8);
        check("m2_own2", 8'(if_m2.led), 8'h4);
        key = 3'b111;
        tick(8);
        check("m2_rel_no_effect", 8'(if_m2.led), 8'h4);
        key = 3'b100;
        tick(6);
        check("m2_simul_pulse", 8'(if_m2.press_pulse), 8'h3);
        check("m2_simul_led", 8'(if_m2.led), 8'h1);
        key = 3'b111;
        tick(8);
        key = 3'b110;
        tick(8);
        check("m2_owner_again", 8'(if_m2.led), 8'h1);
        key = 3'b111;
        tick(8);

        // 6: reset mid-debounce with the key held through it
        do_reset();
        tick(4);
        key = 3'b110;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("m1_midrst_led", 8'(if_m1.led), 8'h0);
        check("m1_midrst_pressed", 8'(if_m1.pressed), 8'h0);
        tick(5);
        check("m1_midrst_early", 8'(if_m1.led), 8'h0);
        tick(1);
        check("m1_midrst_fresh", 8'(if_m1.led), 8'h1);
        key = 3'b111;
        tick(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
